hwag_coil_scheduler: RTL and testbench

// Per-channel ignition coil sequencer driven by the HWAG angle counter (acnt). Software writes

---
 rtl/hwag_coil_scheduler.sv | 89 ++++++++
 tb/tb_hwag_coil_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hwag_coil_scheduler.sv
// hwag_coil_scheduler: per-channel coil sequencer, charge->ignition angle window on the HWAG acnt
// clk/rst          clock, asynchronous active-low reset
// ena              global enable, all state holds when low
// hwag_start       angle valid; low forces every channel to IDLE
// acnt_ena/acnt    angle tick strobe and current angle
// wr_*             shadow write port, wr_ack/wr_err registered one cycle later
// err_clr          per-channel clear of the sticky dwell error
// coil_out/pend/dwell_err  coil drive, uncommitted shadow flag, dwell cut-off flag
module hwag_coil_scheduler #(
  parameter int CH = 4,
  parameter int AW = 24,
  parameter int ACNT_TOP = 3839,
  parameter int MAX_DWELL = 1024
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          hwag_start,
  input  logic          acnt_ena,
  input  logic [AW-1:0] acnt,
  input  logic          wr_req,
  input  logic [2:0]    wr_ch,
  input  logic [AW-1:0] wr_charge,
  input  logic [AW-1:0] wr_ign,
  output logic          wr_ack,
  output logic          wr_err,
  input  logic [CH-1:0] err_clr,
  output logic [CH-1:0] coil_out,
  output logic [CH-1:0] pend,
  output logic [CH-1:0] dwell_err
);
  localparam int DW = MAX_DWELL > 1 ? $clog2(MAX_DWELL) : 1;
  typedef enum logic [1:0] {IDLE, ARMED, CHARGE} st_t;
  logic wr_ok;
  assign wr_ok = wr_req && ({1'b0, wr_ch} < 4'(CH)) && wr_charge <= AW'(ACNT_TOP)
              && wr_ign <= AW'(ACNT_TOP) && wr_charge != wr_ign;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= ena && wr_ok;
      wr_err <= ena && wr_req && !wr_ok;
    end
  genvar i;
  for (i = 0; i < CH; i++) begin : g_ch
    st_t st, st_nx;
    logic [AW-1:0] sh_c, sh_i, ac_c, ac_i;
    logic [DW-1:0] cnt;
    logic p, e, coil, hit, ch_m, ign_m, cut, commit;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        st   <= IDLE;
        sh_c <= '0;
        sh_i <= '0;
        ac_c <= '0;
        ac_i <= '0;
        cnt  <= '0;
        p    <= 1'b0;
        e    <= 1'b0;
      end else if (ena) begin
        st  <= st_nx;
        cnt <= st != CHARGE ? '0 : acnt_ena ? cnt + 1'b1 : cnt;
        // commit reads the old shadow, a same-cycle write lands afterwards and keeps pend set
        ac_c <= commit ? sh_c : ac_c;
        ac_i <= commit ? sh_i : ac_i;
        sh_c <= hit ? wr_charge : sh_c;
        sh_i <= hit ? wr_ign : sh_i;
        p    <= hit || (p && !commit);
        e    <= cut || (e && !err_clr[i]);
      end
    always_comb begin
      hit    = wr_ok && wr_ch == 3'(i);
      ch_m   = acnt_ena && acnt == ac_c;
      ign_m  = acnt_ena && acnt == ac_i;
      // ignition match outranks the dwell cut-off on the same tick
      cut    = hwag_start && st == CHARGE && acnt_ena && !ign_m && cnt == DW'(MAX_DWELL - 1);
      commit = hwag_start && p && (st == IDLE || (st == ARMED && acnt_ena && !ch_m));
      st_nx  = !hwag_start ? IDLE
             : st == IDLE  ? (p ? ARMED : IDLE)
             : st == ARMED ? (ch_m ? CHARGE : ARMED)
             : (ign_m || cut) ? ARMED : CHARGE;
    end
    always_comb coil = st == CHARGE;
    assign coil_out[i]  = coil;
    assign pend[i]      = p;
    assign dwell_err[i] = e;
  end
endmodule

// File: tb/tb_hwag_coil_scheduler.sv
// tb_hwag_coil_scheduler: scoreboard bench for hwag_coil_scheduler (CH=4, MAX_DWELL=16)
module tb_hwag_coil_scheduler;
  logic clk = 0, rst = 1, ena = 1, hwag_start = 0, acnt_ena = 0, wr_req = 0;
  logic [23:0] acnt = 0, wr_charge = 0, wr_ign = 0;
  logic [2:0] wr_ch = 0;
  logic [3:0] err_clr = 0;
  logic wr_ack, wr_err;
  logic [3:0] coil_out, pend, dwell_err;
  logic [3:0] p_coil = 0, p_pend = 0, p_err = 0;
  int n_chk = 0, n_fail = 0;
  typedef struct { logic [3:0] v; int a; } ev_t;
  ev_t q_wr[$], q_pend[$], q_coil[$], q_err[$];
  ev_t e;

  hwag_coil_scheduler #(.CH(4), .AW(24), .ACNT_TOP(3839), .MAX_DWELL(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .hwag_start(hwag_start), .acnt_ena(acnt_ena),
    .acnt(acnt), .wr_req(wr_req), .wr_ch(wr_ch), .wr_charge(wr_charge), .wr_ign(wr_ign),
    .wr_ack(wr_ack), .wr_err(wr_err), .err_clr(err_clr), .coil_out(coil_out),
    .pend(pend), .dwell_err(dwell_err));

  always #5 clk = ~clk;

  task automatic cmp(string nm, logic [3:0] v, int a, ev_t x);
    n_chk++;
    if (v !== x.v || (x.a >= 0 && a != x.a)) begin
      n_fail++;
      $display("FAIL %s: got %b at acnt %0d, expected %b at acnt %0d", nm, v, a, x.v, x.a);
    end
  endtask
  task automatic miss(string nm, logic [3:0] v);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected output %b at acnt %0d, expected none", nm, v, acnt);
  endtask
  task automatic chk_now(string nm, logic [3:0] got, logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_ack || wr_err) begin
      if (q_wr.size() == 0) miss("wr_resp", {2'b0, wr_ack, wr_err});
      else begin e = q_wr.pop_front(); cmp("wr_resp", {2'b0, wr_ack, wr_err}, int'(acnt), e); end
    end
    if (pend !== p_pend) begin
      if (q_pend.size() == 0) miss("pend", pend);
      else begin e = q_pend.pop_front(); cmp("pend", pend, int'(acnt), e); end
    end
    if (coil_out !== p_coil) begin
      if (q_coil.size() == 0) miss("coil_out", coil_out);
      else begin e = q_coil.pop_front(); cmp("coil_out", coil_out, int'(acnt), e); end
    end
    if (dwell_err !== p_err) begin
      if (q_err.size() == 0) miss("dwell_err", dwell_err);
      else begin e = q_err.pop_front(); cmp("dwell_err", dwell_err, int'(acnt), e); end
    end
    p_pend = pend;
    p_coil = coil_out;
    p_err  = dwell_err;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tick(int v);
    acnt = 24'(v);
    acnt_ena = 1;
    cyc();
    acnt_ena = 0;
    cyc();
  endtask
  task automatic wr(int ch, int c, int g, logic ok);
    q_wr.push_back('{ok ? 4'b0010 : 4'b0001, -1});
    wr_req = 1; wr_ch = 3'(ch); wr_charge = 24'(c); wr_ign = 24'(g);
    cyc();
    wr_req = 0;
    cyc();
    cyc();
  endtask
  function automatic void xp(int k, logic [3:0] v, int a);
    if (k == 0) q_pend.push_back('{v, a});
    else if (k == 1) q_coil.push_back('{v, a});
    else q_err.push_back('{v, a});
  endfunction

  initial begin
    #2 rst = 0;
    repeat (3) cyc();
    rst = 1;
    cyc();
    chk_now("reset coil_out", coil_out, 4'b0);
    chk_now("reset pend", pend, 4'b0);
    chk_now("reset dwell_err", dwell_err, 4'b0);
    chk_now("reset wr_resp", {2'b0, wr_ack, wr_err}, 4'b0);
    hwag_start = 1;
    cyc();
    // basic window 100..160 on ch0
    xp(0, 4'b0001, 0); xp(0, 4'b0000, 0);
    xp(1, 4'b0001, 100); xp(1, 4'b0000, 160);
    wr(0, 100, 160, 1);
    tick(100); tick(130); tick(160);
    // wrap-around window 3800..20 on ch1
    xp(0, 4'b0010, 160); xp(0, 4'b0000, 160);
    xp(1, 4'b0010, 3800); xp(1, 4'b0000, 20);
    wr(1, 3800, 20, 1);
    tick(3800); tick(3839); tick(0); tick(20);
    // rewrite during CHARGE: old pulse finishes, commit on the next tick
    xp(1, 4'b0001, 100); xp(1, 4'b0000, 160); xp(1, 4'b0001, 200); xp(1, 4'b0000, 260);
    xp(0, 4'b0001, 130); xp(0, 4'b0000, 161);
    tick(100); tick(130);
    wr(0, 200, 260, 1);
    tick(160); tick(161); tick(200); tick(260);
    // rejected writes, then the ACNT_TOP boundary accepted
    wr(0, 4000, 4100, 0);
    wr(2, 50, 50, 0);
    wr(5, 10, 20, 0);
    wr(1, 10, 3840, 0);
    xp(0, 4'b0100, 260); xp(0, 4'b0000, 260);
    wr(2, 3839, 0, 1);
    // dwell cut-off after 16 ticks, then clear
    xp(0, 4'b1000, 260); xp(0, 4'b0000, 260);
    xp(1, 4'b1000, 100); xp(1, 4'b0000, 116);
    xp(2, 4'b1000, 116); xp(2, 4'b0000, 116);
    wr(3, 100, 300, 1);
    for (int v = 100; v <= 116; v++) tick(v);
    err_clr = 4'b1000;
    cyc();
    err_clr = 0;
    cyc();
    // ignition on the same tick as the dwell limit: no error
    xp(0, 4'b1000, 116); xp(0, 4'b0000, 117);
    xp(1, 4'b1000, 120); xp(1, 4'b0000, 136);
    wr(3, 120, 136, 1);
    for (int v = 117; v <= 136; v++) tick(v);
    // hwag_start drop mid-charge keeps pend
    xp(1, 4'b0001, 200); xp(1, 4'b0000, 200);
    xp(0, 4'b0010, 200); xp(0, 4'b0000, 200);
    tick(200);
    wr(1, 500, 600, 1);
    hwag_start = 0;
    repeat (3) cyc();
    hwag_start = 1;
    repeat (2) cyc();
    // async reset mid-charge
    xp(0, 4'b0001, 200); xp(0, 4'b0000, 200);
    xp(1, 4'b0001, 300); xp(1, 4'b0000, 300);
    wr(0, 300, 400, 1);
    tick(300);
    rst = 0;
    #1;
    chk_now("rst_async coil_out", coil_out, 4'b0);
    repeat (2) cyc();
    rst = 1;
    repeat (4) cyc();
    n_chk++; if (q_wr.size() != 0) begin n_fail++; $display("FAIL wr_resp: %0d responses missing, expected 0", q_wr.size()); end
    n_chk++; if (q_pend.size() != 0) begin n_fail++; $display("FAIL pend: %0d changes missing, expected 0", q_pend.size()); end
    n_chk++; if (q_coil.size() != 0) begin n_fail++; $display("FAIL coil_out: %0d edges missing, expected 0", q_coil.size()); end
    n_chk++; if (q_err.size() != 0) begin n_fail++; $display("FAIL dwell_err: %0d changes missing, expected 0", q_err.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
